// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: selects the next fetch address (reset, exception entry,
// ERET return, stall hold, branch, sequential) and flags illegal fetch addresses.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] TEXT_LO    = 32'h0000_3000,
    parameter logic [31:0] TEXT_HI    = 32'h0000_4FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        exc_req,
    input  logic        eret,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        fetch_adel,
    output logic        in_handler,
    output logic        redirect
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t state;

    // No handshake here: redirect is a registered one-cycle pulse, high exactly in the
    // cycle where pc first shows a non-sequential value, so IF/ID can flush on it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            state    <= RUN;
            redirect <= 1'b0;
        end else if (exc_req && state == RUN) begin
            pc       <= HANDLER_PC;
            state    <= HANDLER;
            redirect <= 1'b1;
        end else if (eret && state == HANDLER) begin
            pc       <= epc;
            state    <= RUN;
            redirect <= 1'b1;
        end else if (stall) begin
            redirect <= 1'b0;
        end else if (br_taken) begin
            pc       <= br_target;
            redirect <= 1'b1;
        end else begin
            pc       <= pc + 32'd4;
            redirect <= 1'b0;
        end
    end

    // The block only reports AdEL; CP0 decides when to answer with exc_req.
    assign fetch_adel = (pc[1:0] != 2'b00) | (pc < TEXT_LO) | (pc > TEXT_HI);
    assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Table-driven bench for fetch_ctrl: one vector per clock cycle, plus a hand-written
// asynchronous-reset sequence while the sequencer sits in the handler.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        fetch_adel;
    logic        in_handler;
    logic        redirect;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;

    typedef struct {
        logic        stall;
        logic        br_taken;
        logic [31:0] br_target;
        logic        exc_req;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_adel;
        logic        exp_handler;
        logic        exp_redirect;
    } vec_t;

    vec_t vecs[$];

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .pc         (pc),
        .fetch_adel (fetch_adel),
        .in_handler (in_handler),
        .redirect   (redirect)
    );

    // Clock / reset: 10-unit period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s [%0d]: got 0x%08h, expected 0x%08h", name, idx, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input logic [31:0] e_pc,
                             input logic e_adel, input logic e_hdl, input logic e_red);
        check({tag, ".pc"}, idx, pc, e_pc);
        check({tag, ".fetch_adel"}, idx, {31'd0, fetch_adel}, {31'd0, e_adel});
        check({tag, ".in_handler"}, idx, {31'd0, in_handler}, {31'd0, e_hdl});
        check({tag, ".redirect"}, idx, {31'd0, redirect}, {31'd0, e_red});
    endtask

    task automatic add(input logic s, input logic b, input logic [31:0] t, input logic x,
                       input logic e, input logic [31:0] ep, input logic [31:0] p,
                       input logic a, input logic h, input logic r);
        vec_t v;
        v.stall = s; v.br_taken = b; v.br_target = t; v.exc_req = x; v.eret = e;
        v.epc = ep; v.exp_pc = p; v.exp_adel = a; v.exp_handler = h; v.exp_redirect = r;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        stall = O; br_taken = O; br_target = 32'd0;
        exc_req = O; eret = O; epc = 32'd0;
    endtask

    initial begin
        //   stall br  target        exc eret epc           exp_pc        adel hdl red
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_3004, O, O, O);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_3008, O, O, O);
        add(I, O, 32'h0,         O, O, 32'h0,         32'h0000_3008, O, O, O);
        add(I, O, 32'h0,         O, O, 32'h0,         32'h0000_3008, O, O, O);
        add(O, I, 32'h0000_3100, O, O, 32'h0,         32'h0000_3100, O, O, I);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_3104, O, O, O);
        add(I, I, 32'h0000_3200, I, O, 32'h0,         32'h0000_4180, O, I, I);
        add(O, O, 32'h0,         I, O, 32'h0,         32'h0000_4184, O, I, O);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_4188, O, I, O);
        add(O, I, 32'h0000_4300, O, O, 32'h0,         32'h0000_4300, O, I, I);
        add(I, O, 32'h0,         O, I, 32'h0000_3010, 32'h0000_3010, O, O, I);
        add(O, O, 32'h0,         O, I, 32'h0000_3500, 32'h0000_3014, O, O, O);
        add(O, I, 32'h0000_3002, O, O, 32'h0,         32'h0000_3002, I, O, I);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_3006, I, O, O);
        add(O, I, 32'h0000_2FFC, O, O, 32'h0,         32'h0000_2FFC, I, O, I);
        add(O, I, 32'h0000_5000, O, O, 32'h0,         32'h0000_5000, I, O, I);
        add(O, I, 32'h0000_4FFC, O, O, 32'h0,         32'h0000_4FFC, O, O, I);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_5000, I, O, O);
        add(O, I, 32'h0000_3300, I, I, 32'h0000_3400, 32'h0000_4180, O, I, I);
        add(O, O, 32'h0,         I, I, 32'h0000_3020, 32'h0000_3020, O, O, I);
        add(O, I, 32'hFFFF_FFFC, O, O, 32'h0,         32'hFFFF_FFFC, I, O, I);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_0000, I, O, O);
        add(O, O, 32'h0,         I, O, 32'h0,         32'h0000_4180, O, I, I);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_4184, O, I, O);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_4188, O, I, O);
        add(O, O, 32'h0,         O, O, 32'h0,         32'h0000_418C, O, I, O);
        add(O, I, 32'h0000_4190, O, O, 32'h0,         32'h0000_4190, O, I, I);

        drive_idle();
        reset = I;
        #12;
        check_all("reset", 0, 32'h0000_3000, O, O, O);
        reset = O;

        foreach (vecs[i]) begin
            stall     = vecs[i].stall;
            br_taken  = vecs[i].br_taken;
            br_target = vecs[i].br_target;
            exc_req   = vecs[i].exc_req;
            eret      = vecs[i].eret;
            epc       = vecs[i].epc;
            @(posedge clk);
            #1;
            check_all("vec", i, vecs[i].exp_pc, vecs[i].exp_adel,
                      vecs[i].exp_handler, vecs[i].exp_redirect);
        end

        // Asynchronous reset mid-cycle while in HANDLER at 0x4190 with redirect high.
        drive_idle();
        #2;
        reset = I;
        #1;
        check_all("async_reset", 0, 32'h0000_3000, O, O, O);
        #2;
        reset = O;
        @(posedge clk);
        #1;
        check_all("after_reset", 0, 32'h0000_3004, O, O, O);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
